// File: rtl/hamming_main.sv
// hamming_main: 64-bit Hamming channel model (encode, 16-slot bit-flip injection, decode/correct).
// HAMMING_SECDED_EN selects 72-bit SECDED; undefined gives plain (71,64) SEC.
`default_nettype none

module hamming_main (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] message,
  input  logic [7:0]  error_0,
  input  logic [7:0]  error_1,
  input  logic [7:0]  error_2,
  input  logic [7:0]  error_3,
  input  logic [7:0]  error_4,
  input  logic [7:0]  error_5,
  input  logic [7:0]  error_6,
  input  logic [7:0]  error_7,
  input  logic [7:0]  error_8,
  input  logic [7:0]  error_9,
  input  logic [7:0]  error_10,
  input  logic [7:0]  error_11,
  input  logic [7:0]  error_12,
  input  logic [7:0]  error_13,
  input  logic [7:0]  error_14,
  input  logic [7:0]  error_15,
  output logic [63:0] decoded_message,
  output logic [7:0]  error_positions
);

  localparam int DATA_W  = 64;
  localparam int NUM_ERR = 16;
  localparam int CW_W    = 72;

  logic [7:0]      err [NUM_ERR];
  logic [CW_W-1:0] cw;
  logic [CW_W-1:0] rx;
  logic [CW_W-1:0] fixed;
  logic [6:0]      syn;
  logic [DATA_W-1:0] data_next;
  logic [7:0]      pos_next;

  assign err[0]  = error_0;
  assign err[1]  = error_1;
  assign err[2]  = error_2;
  assign err[3]  = error_3;
  assign err[4]  = error_4;
  assign err[5]  = error_5;
  assign err[6]  = error_6;
  assign err[7]  = error_7;
  assign err[8]  = error_8;
  assign err[9]  = error_9;
  assign err[10] = error_10;
  assign err[11] = error_11;
  assign err[12] = error_12;
  assign err[13] = error_13;
  assign err[14] = error_14;
  assign err[15] = error_15;

  // Data bits fill non-power-of-two positions ascending from 3.
  always_comb begin : encode
    int  k;
    logic pb;
    cw = '0;
    k  = 0;
    for (int p = 3; p < CW_W; p++) begin
      if ((p & (p - 1)) != 0) begin
        cw[p] = message[k[5:0]];
        k = k + 1;
      end
    end
    for (int j = 0; j < 7; j++) begin
      pb = 1'b0;
      for (int p = 1; p < CW_W; p++) begin
        if (((p >> j) & 1) != 0) pb = pb ^ cw[p];
      end
      cw[1 << j] = pb;
    end
`ifdef HAMMING_SECDED_EN
    cw[0] = ^cw[CW_W-1:1];
`endif
  end

  always_comb begin : inject
    rx = cw;
    for (int s = 0; s < NUM_ERR; s++) begin
`ifdef HAMMING_SECDED_EN
      if (!err[s][7] && (err[s][6:0] <= 7'(CW_W - 1)))
`else
      if (!err[s][7] && (err[s][6:0] <= 7'(CW_W - 1)) && (err[s][6:0] != 7'd0))
`endif
        rx[err[s][6:0]] = ~rx[err[s][6:0]];
    end
  end

  always_comb begin : decode
    int k;
    syn = '0;
    for (int p = 1; p < CW_W; p++) begin
      if (rx[p]) syn = syn ^ 7'(p);
    end
    fixed    = rx;
    pos_next = {1'b0, syn};
`ifdef HAMMING_SECDED_EN
    if (^rx) begin
      if (syn <= 7'(CW_W - 1)) fixed[syn] = ~fixed[syn];
    end else if (syn != 7'd0) begin
      pos_next = {1'b1, syn};
    end
`else
    if ((syn != 7'd0) && (syn <= 7'(CW_W - 1))) fixed[syn] = ~fixed[syn];
`endif
    data_next = '0;
    k = 0;
    for (int p = 3; p < CW_W; p++) begin
      if ((p & (p - 1)) != 0) begin
        data_next[k[5:0]] = fixed[p];
        k = k + 1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      decoded_message <= '0;
      error_positions <= '0;
    end else begin
      decoded_message <= data_next;
      error_positions <= pos_next;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hamming_main.sv
// tb_hamming_main: directed scoreboard bench for hamming_main (message fixed at 0123456789ABCDEF).
`default_nettype none

module tb_hamming_main;

  typedef struct {
    logic [63:0] dec;
    logic [7:0]  pos;
    string       tag;
  } exp_t;

  localparam logic [63:0] MSG = 64'h0123456789ABCDEF;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] message;
  logic [7:0]  err [16];
  logic [63:0] decoded_message;
  logic [7:0]  error_positions;

  exp_t q [$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  hamming_main dut (
    .clk(clk), .rst(rst), .message(message),
    .error_0(err[0]),   .error_1(err[1]),   .error_2(err[2]),   .error_3(err[3]),
    .error_4(err[4]),   .error_5(err[5]),   .error_6(err[6]),   .error_7(err[7]),
    .error_8(err[8]),   .error_9(err[9]),   .error_10(err[10]), .error_11(err[11]),
    .error_12(err[12]), .error_13(err[13]), .error_14(err[14]), .error_15(err[15]),
    .decoded_message(decoded_message),
    .error_positions(error_positions)
  );

  task automatic clear_slots();
    for (int i = 0; i < 16; i++) err[i] = 8'h80;
  endtask

  // Drive current inputs, queue the expectation, then check one cycle later.
  task automatic step(input logic [63:0] d, input logic [7:0] p, input string tag);
    exp_t e;
    @(negedge clk);
    e.dec = d; e.pos = p; e.tag = tag;
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    n_checks++;
    assert (decoded_message === e.dec)
    else begin
      n_fail++;
      $error("FAIL %s.decoded got %h want %h", e.tag, decoded_message, e.dec);
    end
    n_checks++;
    assert (error_positions === e.pos)
    else begin
      n_fail++;
      $error("FAIL %s.positions got %h want %h", e.tag, error_positions, e.pos);
    end
  endtask

  initial begin
    rst = 1'b1;
    message = MSG;
    clear_slots();
    err[0] = 8'h03;
    step(64'h0, 8'h00, "reset");

    rst = 1'b0;
    clear_slots();
    step(MSG, 8'h00, "clean");

    err[0] = 8'h01;
    step(MSG, 8'h01, "single_p1");

    err[1] = 8'h06; err[2] = 8'h09;
    step(64'h0123456789ABCFFB, 8'h0E, "triple_miscorrect");

    for (int i = 0; i < 16; i++) err[i] = 8'(i);
    step(64'h0123456789ABCA10, 8'h00, "sixteen_alias");

    clear_slots();
    err[0] = 8'h03; err[1] = 8'h05;
`ifdef HAMMING_SECDED_EN
    step(64'h0123456789ABCDEC, 8'h86, "double");
`else
    step(64'h0123456789ABCDE8, 8'h06, "double_as_single");
`endif

    clear_slots();
    err[7] = 8'h47;
    step(MSG, 8'h47, "single_p71");

    clear_slots();
    err[3] = 8'h48; err[4] = 8'h7F;
    step(MSG, 8'h00, "out_of_range");

    clear_slots();
    err[5] = 8'h20; err[9] = 8'h20;
    step(MSG, 8'h00, "duplicate_cancel");

    clear_slots();
    err[2] = 8'h85; err[6] = 8'hC7;
    step(MSG, 8'h00, "disabled_slots");

    clear_slots();
    err[0] = 8'h00;
    step(MSG, 8'h00, "position0");

    clear_slots();
    err[1] = 8'h0A;
    step(MSG, 8'h0A, "single_p10");

    rst = 1'b1;
    step(64'h0, 8'h00, "midstream_reset");

    rst = 1'b0;
    clear_slots();
    step(MSG, 8'h00, "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
